// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default widths, pointer type and Gray-code helpers.
// The helpers work on zero-extended 32-bit values, so callers of any width cast in and out.
package fifo_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned PTR_W_DEF  = ADDR_W_DEF + 1;
   localparam int unsigned CODE_W     = 32;

   typedef logic [PTR_W_DEF-1:0] ptr_t;

   function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits make the prefix-XOR correct for any narrower width.
   function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
      logic [CODE_W-1:0] b;
      b = '0;
      b[CODE_W-1] = g[CODE_W-1];
      for (int i = CODE_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/ff_sync.sv
// Two-flop synchronizer for a Gray-coded bus crossing into clk.
module ff_sync #(
   parameter int unsigned SIZE = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] d,
   output logic [SIZE-1:0] q
);

   logic [SIZE-1:0] meta_q;
   logic [SIZE-1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/fifo_rd_arb_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, occupancy flags,
// round-robin pop arbitration among consumers and tagged read-data return.
module fifo_rd_arb_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned AE_THRESH = 2,
   parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W:0]   wptr_gray,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic [ID_W-1:0]   rid,
   output logic [ADDR_W:0]   rptr_gray,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [PTR_W-1:0]  wq2;
   logic [PTR_W-1:0]  wbin_c;
   logic [PTR_W-1:0]  rbin_q, rbin_d;
   logic [PTR_W-1:0]  rptr_gray_q, rptr_gray_d;
   logic [ID_W-1:0]   rr_last_q, rr_last_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [ID_W-1:0]   winner_c, cand_c;
   logic              found_c, pop_c;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

   ff_sync #(.SIZE(PTR_W)) u_wptr_sync (
      .clk (clk),
      .rst (rst),
      .d   (wptr_gray),
      .q   (wq2)
   );

   // Flags decode only flopped state, so a new wptr is visible two edges after it changes.
   always_comb begin
      wbin_c       = PTR_W'(gray2bin(CODE_W'(wq2)));
      count        = wbin_c - rbin_q;
      empty        = (rptr_gray_q == wq2);
      almost_empty = (CODE_W'(count) <= AE_THRESH);
   end

   // Round robin: first requester after the last winner, wrapping.
   always_comb begin
      winner_c = rr_last_q;
      cand_c   = '0;
      found_c  = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand_c = ID_W'((CODE_W'(rr_last_q) + k) % NUM_REQ);
         if (!found_c && req[cand_c]) begin
            winner_c = cand_c;
            found_c  = 1'b1;
         end
      end
   end

   assign pop_c     = (|req) & ~empty;
   assign gnt       = pop_c ? (NUM_REQ'(1) << winner_c) : '0;
   assign ram_rd_en = pop_c;
   assign ram_raddr = rbin_q[ADDR_W-1:0];

   always_comb begin
      rbin_d       = rbin_q + PTR_W'(pop_c);
      rptr_gray_d  = PTR_W'(bin2gray(CODE_W'(rbin_d)));
      rr_last_d    = pop_c ? winner_c : rr_last_q;
      rvalid_d     = pop_c;
      rid_d        = pop_c ? winner_c : rid_q;
      rdata_hold_d = rvalid_q ? ram_rdata : rdata_hold_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rbin_q       <= '0;
         rptr_gray_q  <= '0;
         rr_last_q    <= ID_W'(NUM_REQ - 1);
         rvalid_q     <= 1'b0;
         rid_q        <= '0;
         rdata_hold_q <= '0;
      end else begin
         rbin_q       <= rbin_d;
         rptr_gray_q  <= rptr_gray_d;
         rr_last_q    <= rr_last_d;
         rvalid_q     <= rvalid_d;
         rid_q        <= rid_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

   // RAM output is already registered; pass it through on the return cycle, hold otherwise.
   assign rdata     = rvalid_q ? ram_rdata : rdata_hold_q;
   assign rvalid    = rvalid_q;
   assign rid       = rid_q;
   assign rptr_gray = rptr_gray_q;

endmodule

// File: tb/tb_fifo_rd_arb_ctrl.sv
// Bench for fifo_rd_arb_ctrl: a write-side/RAM stub plus a queue-based reference of
// occupancy, round-robin ownership and returned data order.
module tb_fifo_rd_arb_ctrl;

   localparam int NR = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] wptr_gray;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       ram_rd_en;
   logic [3:0] ram_raddr;
   logic [7:0] ram_rdata;
   logic [7:0] rdata;
   logic       rvalid;
   logic [1:0] rid;
   logic [4:0] rptr_gray;
   logic       empty;
   logic       almost_empty;
   logic [4:0] count;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem [16];
   logic [7:0]  exp_q [$];
   int unsigned w_bin = 0;
   int unsigned m_w1 = 0, m_w2 = 0, m_rd = 0;
   int          m_last = NR - 1;
   int          m_g;
   logic        m_rv = 1'b0;
   int          m_rid = 0;
   logic [7:0]  m_rdata = '0;

   fifo_rd_arb_ctrl #(.ADDR_W(4), .DATA_W(8), .NUM_REQ(4), .AE_THRESH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .wptr_gray    (wptr_gray),
      .req          (req),
      .gnt          (gnt),
      .ram_rd_en    (ram_rd_en),
      .ram_raddr    (ram_raddr),
      .ram_rdata    (ram_rdata),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .rid          (rid),
      .rptr_gray    (rptr_gray),
      .empty        (empty),
      .almost_empty (almost_empty),
      .count        (count)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM stub
   always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_raddr];

   function automatic logic [4:0] to_gray(input int unsigned b);
      logic [4:0] x;
      x = 5'(b);
      return x ^ (x >> 1);
   endfunction

   function automatic int m_count();
      return int'((m_w2 + 32 - m_rd) % 32);
   endfunction

   function automatic int exp_win();
      if (m_count() == 0 || req == 4'b0) return -1;
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (m_last + k) % NR;
         if (req[i[1:0]]) return i;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_gnt();
      int w;
      w = exp_win();
      return (w < 0) ? 4'b0 : 4'(1 << w);
   endfunction

   // Reference: write count seen two edges late; one pop per edge when data is visible.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_w1 = 0; m_w2 = 0; m_rd = 0; m_last = NR - 1;
         m_rv = 1'b0; m_rid = 0; m_rdata = '0;
      end else begin
         m_g = exp_win();
         if (m_g >= 0) begin
            m_rd    = (m_rd + 1) % 32;
            m_last  = m_g;
            m_rv    = 1'b1;
            m_rid   = m_g;
            m_rdata = exp_q.pop_front();
         end else begin
            m_rv = 1'b0;
         end
         m_w2 = m_w1;
         m_w1 = w_bin;
      end
   end

   task automatic push_entries(input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         mem[4'(w_bin)] = v;
         exp_q.push_back(v);
         w_bin = (w_bin + 1) % 32;
      end
      wptr_gray = to_gray(w_bin);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; req = 4'b0; wptr_gray = 5'b0; w_bin = 0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({rvalid, rid, rdata} !== {1'b0, 2'b0, 8'b0}) begin
         bad++; $display("FAIL reset_ret: got rvalid=%b rid=%0d rdata=%h want 0 0 00", rvalid, rid, rdata);
      end
      rst = 1'b1; req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if ({empty, almost_empty, gnt, ram_rd_en, rptr_gray, count} !== {1'b1, 1'b1, 4'b0, 1'b0, 5'b0, 5'b0}) begin
            bad++;
            $display("FAIL reset_idle c%0d: got e=%b ae=%b gnt=%b en=%b rg=%b cnt=%0d want 1 1 0000 0 00000 0",
                     c, empty, almost_empty, gnt, ram_rd_en, rptr_gray, count);
         end
      end
      req = 4'b0;
   endtask

   task automatic test_sync_latency();
      push_entries(3);
      #1;
      total++;
      if (empty !== 1'b1) begin bad++; $display("FAIL sync_e0: got %b want 1", empty); end
      tick();
      total++;
      if ({empty, count} !== {1'b1, 5'd0}) begin
         bad++; $display("FAIL sync_e1: got e=%b cnt=%0d want 1 0", empty, count);
      end
      tick();
      total++;
      if ({empty, count, almost_empty} !== {1'b0, 5'd3, 1'b0}) begin
         bad++; $display("FAIL sync_e2: got e=%b cnt=%0d ae=%b want 0 3 0", empty, count, almost_empty);
      end
   endtask

   task automatic test_rr_all();
      req = 4'b1111;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({gnt, ram_rd_en, ram_raddr} !== {4'(1 << i), 1'b1, 4'(i)} || gnt !== exp_gnt()) begin
            bad++; $display("FAIL rr_all_gnt %0d: got gnt=%b en=%b addr=%0d want %b 1 %0d",
                            i, gnt, ram_rd_en, ram_raddr, 4'(1 << i), i);
         end
         tick();
         total++;
         if ({rvalid, rid, rdata} !== {1'b1, 2'(i), m_rdata}) begin
            bad++; $display("FAIL rr_all_ret %0d: got v=%b id=%0d d=%h want 1 %0d %h", i, rvalid, rid, rdata, i, m_rdata);
         end
      end
      total++;
      if ({empty, gnt, ram_rd_en} !== {1'b1, 4'b0, 1'b0}) begin
         bad++; $display("FAIL rr_all_last: got e=%b gnt=%b en=%b want 1 0000 0", empty, gnt, ram_rd_en);
      end
      tick();
      total++;
      if ({gnt, rvalid, rid, rdata} !== {4'b0, 1'b0, 2'd2, m_rdata}) begin
         bad++; $display("FAIL rr_all_hold: got gnt=%b v=%b id=%0d d=%h want 0000 0 2 %h", gnt, rvalid, rid, rdata, m_rdata);
      end
      req = 4'b0;
   endtask

   task automatic test_alternating();
      push_entries(4);
      tick(); tick();
      total++;
      if ({count, almost_empty} !== {5'd4, 1'b0}) begin
         bad++; $display("FAIL alt_fill: got cnt=%0d ae=%b want 4 0", count, almost_empty);
      end
      for (int burst = 0; burst < 2; burst++) begin
         req = 4'b1010;
         #1;
         for (int n = 0; n < 2; n++) begin
            total++;
            if (gnt !== exp_gnt() || (gnt !== 4'b1000 && gnt !== 4'b0010)) begin
               bad++; $display("FAIL alt_gnt b%0d n%0d: got %b want %b", burst, n, gnt, exp_gnt());
            end
            tick();
            total++;
            if ({rvalid, rid, rdata, count, almost_empty} !==
                {1'b1, 2'(m_rid), m_rdata, 5'(m_count()), 1'(m_count() <= 2)}) begin
               bad++; $display("FAIL alt_ret b%0d n%0d: got v=%b id=%0d d=%h cnt=%0d ae=%b want 1 %0d %h %0d",
                               burst, n, rvalid, rid, rdata, count, almost_empty, m_rid, m_rdata, m_count());
            end
         end
         req = 4'b0;
         repeat (3) begin
            tick();
            total++;
            if ({gnt, rvalid} !== 5'b0 || count !== 5'(m_count())) begin
               bad++; $display("FAIL alt_idle b%0d: got gnt=%b v=%b cnt=%0d want 0000 0 %0d", burst, gnt, rvalid, count, m_count());
            end
         end
      end
      total++;
      if ({empty, almost_empty, count} !== {1'b1, 1'b1, 5'd0}) begin
         bad++; $display("FAIL alt_end: got e=%b ae=%b cnt=%0d want 1 1 0", empty, almost_empty, count);
      end
   endtask

   task automatic test_wrap_random();
      for (int pass = 0; pass < 3; pass++) begin
         int guard;
         push_entries(16);
         guard = 0;
         while (!(m_rd == w_bin && !m_rv && m_w2 == w_bin) && guard < 400) begin
            int occ;
            occ = int'((w_bin + 32 - m_rd) % 32);
            req = 4'($urandom_range(0, 15));
            if (guard < 40 && guard > 4 && occ < 16 && $urandom_range(0, 3) == 0)
               push_entries($urandom_range(1, 16 - occ));
            #1;
            total++;
            if (gnt !== exp_gnt() || ram_rd_en !== (exp_gnt() != 4'b0) ||
                (ram_rd_en && ram_raddr !== 4'(m_rd)) || rptr_gray !== to_gray(m_rd) ||
                count !== 5'(m_count()) || count > 5'd16 || empty !== (m_count() == 0) ||
                almost_empty !== (m_count() <= 2)) begin
               bad++; $display("FAIL wrap_ctl p%0d g%0d: got gnt=%b en=%b addr=%0d rg=%b cnt=%0d e=%b ae=%b want gnt=%b rd=%0d rg=%b cnt=%0d",
                               pass, guard, gnt, ram_rd_en, ram_raddr, rptr_gray, count, empty, almost_empty,
                               exp_gnt(), m_rd, to_gray(m_rd), m_count());
            end
            tick();
            total++;
            if (rvalid !== m_rv || (m_rv && (rid !== 2'(m_rid) || rdata !== m_rdata))) begin
               bad++; $display("FAIL wrap_ret p%0d g%0d: got v=%b id=%0d d=%h want %b %0d %h",
                               pass, guard, rvalid, rid, rdata, m_rv, m_rid, m_rdata);
            end
            guard++;
         end
         if (guard >= 400) begin
            total++; bad++;
            $display("FAIL wrap_timeout p%0d: got rd=%0d want %0d", pass, m_rd, w_bin);
         end
      end
      req = 4'b0;
   endtask

   task automatic test_reset_mid();
      push_entries(3);
      tick(); tick();
      req = 4'b1111;
      #1;
      total++;
      if (gnt === 4'b0 || gnt !== exp_gnt()) begin
         bad++; $display("FAIL mid_pre: got gnt=%b want %b", gnt, exp_gnt());
      end
      tick();
      total++;
      if (rvalid !== 1'b1) begin bad++; $display("FAIL mid_pop: got rvalid=%b want 1", rvalid); end
      rst = 1'b0;
      w_bin = 0; wptr_gray = 5'b0; exp_q.delete();
      #1;
      total++;
      if ({rvalid, empty, rptr_gray, count, gnt, rid, rdata} !== {1'b0, 1'b1, 5'b0, 5'b0, 4'b0, 2'b0, 8'b0}) begin
         bad++; $display("FAIL mid_rst: got v=%b e=%b rg=%b cnt=%0d gnt=%b id=%0d d=%h want 0 1 0 0 0 0 0",
                         rvalid, empty, rptr_gray, count, gnt, rid, rdata);
      end
      tick();
      rst = 1'b1;
      push_entries(2);
      tick(); tick();
      total++;
      if (gnt !== 4'b0001 || gnt !== exp_gnt()) begin
         bad++; $display("FAIL mid_first: got gnt=%b want 0001", gnt);
      end
      tick();
      total++;
      if ({rvalid, rid, rdata} !== {1'b1, 2'd0, m_rdata}) begin
         bad++; $display("FAIL mid_ret: got v=%b id=%0d d=%h want 1 0 %h", rvalid, rid, rdata, m_rdata);
      end
      req = 4'b0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_sync_latency();
      test_rr_all();
      test_alternating();
      test_wrap_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
